// File: rtl/mant_align_if.sv
// Operand/result bundle between exponent subtraction, the mantissa aligner
// and the significand adder: valid/ready on both sides.
interface mant_align_if #(
    parameter int ex_width  = 8,
    parameter int man_width = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic [man_width:0]     Ma;
    logic [man_width:0]     Mb;
    logic [ex_width:0]      d;
    logic                   sign_exp;
    logic [ex_width-1:0]    max_exp;

    logic                   out_valid;
    logic                   out_ready;
    logic [man_width+3:0]   big_m;
    logic [man_width+3:0]   small_m;
    logic [ex_width-1:0]    exp_out;
    logic                   swap;

    modport master (
        output in_valid, Ma, Mb, d, sign_exp, max_exp, out_ready,
        input  in_ready, out_valid, big_m, small_m, exp_out, swap
    );

    modport slave (
        input  in_valid, Ma, Mb, d, sign_exp, max_exp, out_ready,
        output in_ready, out_valid, big_m, small_m, exp_out, swap
    );
endinterface

// File: rtl/mant_align.sv
// Mantissa alignment: right-shifts the smaller-exponent mantissa by d, at most
// SHIFT_STEP places per cycle, folding every bit shifted out into sticky.
module mant_align #(
    parameter int ex_width   = 8,
    parameter int man_width  = 23,
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mant_align_if.slave bus
);
    localparam int MW = man_width + 4;
    localparam int RW = $clog2(man_width + 5);
    localparam int SW = $clog2(SHIFT_STEP + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [MW-1:0]       big_reg, big_next;
    logic [MW-1:0]       sh_reg, sh_next;
    logic [ex_width-1:0] exp_reg, exp_next;
    logic                swap_reg, swap_next;
    logic [RW-1:0]       rem_reg, rem_next;

    logic [31:0]         d_wide;
    logic [RW-1:0]       d_clamped;
    logic [RW-1:0]       step;
    logic [SW-1:0]       step_idx;
    logic [MW-1:0]       cand [SHIFT_STEP+1];

    // Any distance past the full register width flushes everything to sticky.
    assign d_wide    = 32'(bus.d);
    assign d_clamped = (d_wide > 32'(MW)) ? RW'(MW) : RW'(bus.d);

    assign step     = (rem_reg < RW'(SHIFT_STEP)) ? rem_reg : RW'(SHIFT_STEP);
    assign step_idx = SW'(step);

    // One candidate per possible shift distance; bit 0 of each ORs together
    // everything at or below the bit that lands in position 0.
    generate
        for (genvar gi = 0; gi <= SHIFT_STEP; gi++) begin : g_cand
            if (gi == 0) begin : g_zero
                assign cand[gi] = sh_reg;
            end else begin : g_shift
                logic [MW-1:0] moved;
                assign moved    = sh_reg >> gi;
                assign cand[gi] = {moved[MW-1:1], |sh_reg[gi:0]};
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        big_next   = big_reg;
        sh_next    = sh_reg;
        exp_next   = exp_reg;
        swap_next  = swap_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.sign_exp) begin
                        big_next = {bus.Mb, 3'b000};
                        sh_next  = {bus.Ma, 3'b000};
                    end else begin
                        big_next = {bus.Ma, 3'b000};
                        sh_next  = {bus.Mb, 3'b000};
                    end
                    exp_next   = bus.max_exp;
                    swap_next  = bus.sign_exp;
                    rem_next   = d_clamped;
                    state_next = (d_clamped != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sh_next  = cand[step_idx];
                rem_next = rem_reg - step;
                if (rem_reg == step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            big_reg   <= '0;
            sh_reg    <= '0;
            exp_reg   <= '0;
            swap_reg  <= 1'b0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            big_reg   <= big_next;
            sh_reg    <= sh_next;
            exp_reg   <= exp_next;
            swap_reg  <= swap_next;
            rem_reg   <= rem_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.big_m     = big_reg;
    assign bus.small_m   = sh_reg;
    assign bus.exp_out   = exp_reg;
    assign bus.swap      = swap_reg;
endmodule

// File: tb/tb_mant_align.sv
// Bench for mant_align: directed and random operations checked against an
// arithmetic model of right-shift-with-sticky and the expected latency.
module tb_mant_align;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mant_align_if #(.ex_width(8), .man_width(23)) bus ();

    mant_align #(
        .ex_width  (8),
        .man_width (23),
        .SHIFT_STEP(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift {m,000} right by min(d,27); bit 0 becomes set if any 1 was lost.
    function automatic logic [26:0] model_small(input logic [23:0] m, input logic [8:0] dd);
        logic [63:0] full;
        logic [63:0] lost;
        int          k;
        full = {37'd0, m, 3'd0};
        k = int'(dd);
        if (k > 27) k = 27;
        lost = full & ((64'd1 << k) - 64'd1);
        return 27'((full >> k) | {63'd0, (lost != 64'd0)});
    endfunction

    task automatic scramble_inputs();
        bus.Ma       = 24'($urandom);
        bus.Mb       = 24'($urandom);
        bus.d        = 9'($urandom);
        bus.sign_exp = 1'($urandom);
        bus.max_exp  = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({tag, "_big_m"},     64'(bus.big_m),     64'd0);
        check({tag, "_small_m"},   64'(bus.small_m),   64'd0);
        check({tag, "_exp_out"},   64'(bus.exp_out),   64'd0);
        check({tag, "_swap"},      64'(bus.swap),      64'd0);
    endtask

    task automatic run_op(input logic [23:0] ma, input logic [23:0] mb, input logic [8:0] dd,
                          input logic se, input logic [7:0] me, input int bp);
        logic [26:0] exp_big;
        logic [26:0] exp_small;
        int          k;
        int          exp_lat;
        int          lat;
        exp_big   = se ? {mb, 3'b000} : {ma, 3'b000};
        exp_small = model_small(se ? ma : mb, dd);
        k = int'(dd);
        if (k > 27) k = 27;
        exp_lat = 1 + (k + 3) / 4;

        @(negedge clk);
        bus.Ma = ma; bus.Mb = mb; bus.d = dd; bus.sign_exp = se; bus.max_exp = me;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);

        @(posedge clk); #1;
        lat = 1;
        bus.in_valid = 1'($urandom);
        scramble_inputs();
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bus.in_valid = 1'($urandom);
            scramble_inputs();
        end
        check("latency", 64'(lat), 64'(exp_lat));

        for (int c = 0; c <= bp; c++) begin
            check("out_valid", 64'(bus.out_valid), 64'd1);
            check("in_ready_busy", 64'(bus.in_ready), 64'd0);
            check("big_m",   64'(bus.big_m),   64'(exp_big));
            check("small_m", 64'(bus.small_m), 64'(exp_small));
            check("exp_out", 64'(bus.exp_out), 64'(me));
            check("swap",    64'(bus.swap),    64'(se));
            if (c < bp) begin
                @(negedge clk);
                bus.in_valid = ~bus.in_valid;
                scramble_inputs();
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("released_out_valid", 64'(bus.out_valid), 64'd0);
        check("released_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("op Ma=%06h Mb=%06h d=%0d sign_exp=%0b max_exp=%02h bp=%0d -> big_m=%07h small_m=%07h latency=%0d",
                 ma, mb, dd, se, me, bp, exp_big, exp_small, lat);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Ma = '0; bus.Mb = '0; bus.d = '0; bus.sign_exp = 1'b0; bus.max_exp = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(24'h800000, 24'hC00000, 9'd1,  1'b0, 8'h7F, 0);
        run_op(24'h800000, 24'hA00000, 9'd0,  1'b0, 8'h80, 0);
        run_op(24'h9ABCDE, 24'h800001, 9'd5,  1'b0, 8'h81, 0);
        run_op(24'hFFFFFF, 24'h800000, 9'd30, 1'b1, 8'h90, 0);
        run_op(24'hABCDEF, 24'h912345, 9'd9,  1'b1, 8'h55, 5);
        run_op(24'hF00000, 24'h800000, 9'd27, 1'b0, 8'h01, 1);
        run_op(24'h800000, 24'hFFFFFF, 9'd26, 1'b1, 8'hFE, 0);
        run_op(24'hC3C3C3, 24'h8F0F0F, 9'd511, 1'b0, 8'hAA, 0);

        // Abort an operation part-way through its shift sequence.
        @(negedge clk);
        bus.Ma = 24'hDEADBE; bus.Mb = 24'h8BEEF1; bus.d = 9'd20; bus.sign_exp = 1'b0; bus.max_exp = 8'h42;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_shift_busy", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(24'h812345, 24'hFEDCBA, 9'd20, 1'b1, 8'h42, 0);

        for (int i = 0; i < 30; i++) begin
            logic [8:0] dd;
            case ($urandom_range(0, 3))
                0:       dd = 9'($urandom_range(0, 8));
                1:       dd = 9'($urandom_range(9, 27));
                2:       dd = 9'($urandom_range(28, 511));
                default: dd = 9'($urandom_range(0, 30));
            endcase
            run_op({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, dd, 1'($urandom),
                   8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mant_align.md
# mant_align

Mantissa alignment stage of the floating-point add/sub datapath, directly downstream of exponent subtraction. Takes the two hidden-bit mantissas plus the exponent difference `d`, swap flag `sign_exp` and `max_exp` from `exp_sub`. It right-shifts the smaller-exponent mantissa by `d` using a bounded iterative shifter, producing guard, round and sticky bits. Results go out over a valid/ready handshake to the significand adder.

## Interface

Parameters:
- `ex_width`, 8: exponent width.
- `man_width`, 23: stored fraction width. Mantissas carry the hidden bit, so they are `man_width+1` bits.
- `SHIFT_STEP`, 4: maximum right-shift distance per cycle. Must be a power of two and at least 1.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: upstream operands valid.
- `in_ready`  out  1: block can accept. Equal to (state == IDLE).
- `Ma`, `Mb`  in  `man_width+1` each: mantissas with hidden bit.
- `d`  in  `ex_width+1`: absolute exponent difference from `exp_sub`.
- `sign_exp`  in  1: 1 means Eb > Ea.
- `max_exp`  in  `ex_width`: larger exponent.
- `out_valid`  out  1: result valid. Equal to (state == DONE).
- `out_ready`  in  1: downstream accepts.
- `big_m`  out  `man_width+4`: larger-exponent mantissa as {M, 3'b000}.
- `small_m`  out  `man_width+4`: aligned mantissa. Bits [2:0] are guard, round and sticky.
- `exp_out`  out  `ex_width`: registered `max_exp`.
- `swap`  out  1: registered `sign_exp`.

## Operation

- States: IDLE, SHIFT, DONE.
- **IDLE.** When `in_valid` is high at a rising edge:
  - Swap: if `sign_exp` = 0, `big_m` ← {Ma,000} and the shift register ← {Mb,000}. Otherwise `big_m` ← {Mb,000} and the shift register ← {Ma,000}.
  - Register `exp_out` and `swap`.
  - `rem` ← min(`d`, `man_width+4`). A clamped shift flushes every bit into sticky.
  - Next state is SHIFT if `rem` ≠ 0, else DONE.
- **SHIFT.** Each cycle:
  - s = min(`rem`, `SHIFT_STEP`); `rem` ← `rem` − s.
  - Shift the register right by s.
  - New bit[0] = OR of the shifted-out bits, the old bit[0], and the bit that lands in position 0. Sticky never clears once set.
  - When the updated `rem` = 0, go to DONE.
- **DONE.**
  - `small_m` shows the shift register.
  - `in_ready` = 0, so `in_valid` is ignored.
  - If `out_ready` = 1 at the edge, go to IDLE. An input is never accepted in the same cycle as output is taken.
- `rem` is a counter of ⌈log2(`man_width+5`)⌉ bits. It cannot underflow, because s ≤ `rem`.
- `d` values above `man_width+4` (up to 2^(`ex_width`+1)−1) all behave as `man_width+4`.

## Timing

- Reset (asynchronous assert, synchronous-safe release):
  - State = IDLE, so `in_ready` = 1 and `out_valid` = 0.
  - `big_m`, `small_m`, `exp_out`, `swap` and `rem` are all zero.
- Latency: `out_valid` rises exactly 1 + ⌈min(`d`, `man_width+4`)/`SHIFT_STEP`⌉ edges after the accepting edge.
  - `d` = 0: 1 cycle.
  - Default parameters, `d` ≥ 27: 8 cycles.
- Outputs hold stable while `out_valid` = 1 and `out_ready` = 0 (backpressure).
- Throughput: one operation per latency + 1 cycles minimum. No pipelining of multiple operations.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation. Outputs return to reset values immediately; no partial result is emitted.
- Inputs are sampled only on the accepting edge. Changes at other times have no effect.

## Test plan

1. **Single-step shift.** Ma=24'h800000, Mb=24'hC00000, d=1, sign_exp=0 → after 2 cycles: `big_m`=27'h4000000, `small_m`=27'h3000000, `swap`=0.
2. **Zero shift.** d=0, Ma=24'h800000, Mb=24'hA00000 → `out_valid` 1 cycle after accept; `small_m`=27'h5000000.
3. **Two-step shift with sticky.** Mb=24'h800001, d=5 → two SHIFT cycles (4 then 1); `small_m`=27'h0200001 (sticky=1).
4. **Swap and clamp.** sign_exp=1, Ma=24'hFFFFFF, Mb=24'h800000, d=30, max_exp=8'h90 → `big_m`=27'h4000000, `small_m`=27'h0000001, `exp_out`=8'h90, `swap`=1, `out_valid` after 8 cycles.
5. **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` → outputs unchanged, `in_ready`=0, no new accept. Raise `out_ready` → IDLE next cycle, `in_ready`=1.
6. **Reset mid-operation.** Assert `rst_n`=0 during SHIFT (d=20) → immediately `out_valid`=0 and `small_m`=0. After release, the next operation completes correctly.
